// File: rtl/bil_sync_gen_pkg.sv
// ---------------------------------------------------------------------------
// bil_sync_gen_pkg
// Shared definitions for the bilateral-filter sync generator front stage.
// Holds the frame-tracking FSM state encoding and the default counter and
// data widths used by bil_sync_gen.
// ---------------------------------------------------------------------------
package bil_sync_gen_pkg;

  // Default widths: 12-bit pixel counter (4095 px/line max), 11-bit line
  // counter (2047 lines max), 8-bit pixel data.
  localparam int DBUF_DW_DEF = 8;
  localparam int HSZ_W_DEF   = 12;
  localparam int VSZ_W_DEF   = 11;

  // S_IDLE : no frame open, waiting for a vsync edge
  // S_FRM  : frame open, waiting for the next line to start
  // S_LINE : forwarding pixels of the current line
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FRM  = 2'd1,
    S_LINE = 2'd2
  } state_t;

endpackage

// File: rtl/bil_sync_gen.sv
// ---------------------------------------------------------------------------
// bil_sync_gen
// Front stage of the bilateral-filter datapath. Turns raw sensor timing
// (level vsync plus data enable) into the hstr/href/hend/vstr/vend pulse set
// consumed by line_buf_v2, registers the pixel data, tracks pixel and line
// indices, and flags malformed lines and frames. One cycle of latency, no
// backpressure.
//
// Ports
//   clk, rst      pixel clock, asynchronous active-high reset
//   i_vsync       raw frame sync (level, active level set by VS_POL)
//   i_de          raw data enable, high during active pixels
//   i_data        raw pixel, valid while i_de = 1
//   r_hsz, r_vsz  expected pixels per line / lines per frame (quasi-static)
//   o_data        pixel aligned with o_href (holds while i_de = 0)
//   o_href        pixel valid
//   o_hstr/o_hend first / last pixel of a line
//   o_vstr/o_vend first pixel of line 0 / last pixel of line r_vsz-1
//   o_hcnt/o_vcnt 0-based pixel index on o_data / current line index
//   o_err_hlen    with o_hend when the line length differs from r_hsz
//   o_err_vlen    frame aborted early, or line seen outside an open frame
// ---------------------------------------------------------------------------
module bil_sync_gen
  import bil_sync_gen_pkg::*;
#(
  parameter int DBUF_DW = DBUF_DW_DEF,
  parameter int HSZ_W   = HSZ_W_DEF,
  parameter int VSZ_W   = VSZ_W_DEF,
  parameter bit VS_POL  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_vsync,
  input  logic               i_de,
  input  logic [DBUF_DW-1:0] i_data,
  input  logic [HSZ_W-1:0]   r_hsz,
  input  logic [VSZ_W-1:0]   r_vsz,
  output logic [DBUF_DW-1:0] o_data,
  output logic               o_href,
  output logic               o_hstr,
  output logic               o_hend,
  output logic               o_vstr,
  output logic               o_vend,
  output logic [HSZ_W-1:0]   o_hcnt,
  output logic [VSZ_W-1:0]   o_vcnt,
  output logic               o_err_hlen,
  output logic               o_err_vlen
);

  localparam logic [HSZ_W-1:0] HONE = HSZ_W'(1);
  localparam logic [VSZ_W-1:0] VONE = VSZ_W'(1);
  localparam logic [HSZ_W:0]   LONE = (HSZ_W + 1)'(1);

  state_t               state_q, state_d;
  logic                 vs_act_q, de_q;
  logic [DBUF_DW-1:0]   data_q, data_d;
  logic                 href_q, href_d;
  logic                 hstr_q, hstr_d;
  logic                 vstr_q, vstr_d;
  logic                 errv_q, errv_d;
  logic [HSZ_W-1:0]     hcnt_q, hcnt_d;
  logic [VSZ_W-1:0]     vcnt_q, vcnt_d;

  logic                 vs_act, vs_rise, de_rise, de_fall;
  logic                 in_line, line_end, last_line;
  logic [HSZ_W-1:0]     hcnt_inc;
  logic [VSZ_W-1:0]     vcnt_inc, vlast;
  logic [HSZ_W:0]       line_len;

  // Edge detection against the registered copies of vsync and data enable.
  assign vs_act  = (i_vsync == VS_POL);
  assign vs_rise = vs_act & ~vs_act_q;
  assign de_rise = i_de & ~de_q;
  assign de_fall = ~i_de & de_q;

  // Saturating increments so a runaway line or frame never wraps to 0.
  assign hcnt_inc = (&hcnt_q) ? hcnt_q : hcnt_q + HONE;
  assign vcnt_inc = (&vcnt_q) ? vcnt_q : vcnt_q + VONE;

  assign vlast     = r_vsz - VONE;
  assign last_line = (vcnt_q == vlast);
  assign line_len  = {1'b0, hcnt_q} + LONE;
  assign in_line   = (state_q == S_LINE);

  // The last pixel of a line is already sitting on o_data when the falling
  // edge of i_de (or an early vsync) is seen, so the end-of-line flags are
  // decoded from the current input against the registered state. They stay
  // aligned with the held pixel and vanish at once on reset.
  assign line_end   = in_line & (de_fall | vs_rise);
  assign o_hend     = line_end;
  assign o_vend     = in_line & de_fall & ~vs_rise & last_line;
  assign o_err_hlen = line_end & (line_len != {1'b0, r_hsz});
  assign o_err_vlen = errv_q;

  assign o_data = data_q;
  assign o_href = href_q;
  assign o_hstr = hstr_q;
  assign o_vstr = vstr_q;
  assign o_hcnt = hcnt_q;
  assign o_vcnt = vcnt_q;

  // Next-state logic. A vsync edge is handled before anything else: it
  // closes whatever was in progress (flagging a short frame if one was
  // open) and, if a line starts in the same cycle, that line becomes line 0.
  // Lines that start while no frame is open are dropped and flagged.
  always_comb begin
    state_d = state_q;
    data_d  = i_de ? i_data : data_q;
    href_d  = 1'b0;
    hstr_d  = 1'b0;
    vstr_d  = 1'b0;
    errv_d  = 1'b0;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;

    if (vs_rise) begin
      errv_d = (state_q != S_IDLE);
      vcnt_d = '0;
      if (de_rise) begin
        state_d = S_LINE;
        href_d  = 1'b1;
        hstr_d  = 1'b1;
        vstr_d  = 1'b1;
        hcnt_d  = '0;
      end else begin
        state_d = S_FRM;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (de_rise) begin
            errv_d = 1'b1;
          end
        end
        S_FRM: begin
          if (de_rise) begin
            state_d = S_LINE;
            href_d  = 1'b1;
            hstr_d  = 1'b1;
            vstr_d  = (vcnt_q == '0);
            hcnt_d  = '0;
          end
        end
        S_LINE: begin
          if (i_de) begin
            href_d = 1'b1;
            hcnt_d = hcnt_inc;
          end else if (last_line) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FRM;
            vcnt_d  = vcnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; everything clears asynchronously so a reset
  // mid-line silences the outputs immediately and waits for a fresh vsync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vs_act_q <= 1'b0;
      de_q     <= 1'b0;
      data_q   <= '0;
      href_q   <= 1'b0;
      hstr_q   <= 1'b0;
      vstr_q   <= 1'b0;
      errv_q   <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      vs_act_q <= vs_act;
      de_q     <= i_de;
      data_q   <= data_d;
      href_q   <= href_d;
      hstr_q   <= hstr_d;
      vstr_q   <= vstr_d;
      errv_q   <= errv_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
    end
  end

endmodule

// File: tb/tb_bil_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_bil_sync_gen
// Self-checking bench for bil_sync_gen. A line/frame-level reference model
// predicts every output each cycle from the raw sensor timing; directed
// scenarios also check event totals against constants.
// ---------------------------------------------------------------------------
module tb_bil_sync_gen;

  localparam int DW = 8;
  localparam int HW = 12;
  localparam int VW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_vsync, i_de;
  logic [DW-1:0] i_data;
  logic [HW-1:0] r_hsz;
  logic [VW-1:0] r_vsz;
  logic [DW-1:0] o_data;
  logic          o_href, o_hstr, o_hend, o_vstr, o_vend;
  logic [HW-1:0] o_hcnt;
  logic [VW-1:0] o_vcnt;
  logic          o_err_hlen, o_err_vlen;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: frame open flag, line being forwarded, indices
  bit            mPrevVs, mPrevDe, mOpen, mActive;
  int            mLine, mPix;
  logic [DW-1:0] mData;
  bit            eHref, eHstr, eVstr, eErrv;

  // observed event totals for scenario-level checks
  int cntHref, cntHstr, cntHend, cntVstr, cntVend, cntErrH, cntErrV, cntCoinc;

  bil_sync_gen #(.DBUF_DW(DW), .HSZ_W(HW), .VSZ_W(VW), .VS_POL(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_vsync    (i_vsync),
    .i_de       (i_de),
    .i_data     (i_data),
    .r_hsz      (r_hsz),
    .r_vsz      (r_vsz),
    .o_data     (o_data),
    .o_href     (o_href),
    .o_hstr     (o_hstr),
    .o_hend     (o_hend),
    .o_vstr     (o_vstr),
    .o_vend     (o_vend),
    .o_hcnt     (o_hcnt),
    .o_vcnt     (o_vcnt),
    .o_err_hlen (o_err_hlen),
    .o_err_vlen (o_err_vlen)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPrevVs = 0; mPrevDe = 0; mOpen = 0; mActive = 0;
    mLine = 0; mPix = 0; mData = '0;
    eHref = 0; eHstr = 0; eVstr = 0; eErrv = 0;
  endtask

  task automatic clearCounts();
    cntHref = 0; cntHstr = 0; cntHend = 0; cntVstr = 0;
    cntVend = 0; cntErrH = 0; cntErrV = 0; cntCoinc = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_data"}, 32'(o_data), 0);
    checkOutput({tag, "_href"}, 32'(o_href), 0);
    checkOutput({tag, "_hstr"}, 32'(o_hstr), 0);
    checkOutput({tag, "_hend"}, 32'(o_hend), 0);
    checkOutput({tag, "_vstr"}, 32'(o_vstr), 0);
    checkOutput({tag, "_vend"}, 32'(o_vend), 0);
    checkOutput({tag, "_hcnt"}, 32'(o_hcnt), 0);
    checkOutput({tag, "_vcnt"}, 32'(o_vcnt), 0);
    checkOutput({tag, "_errh"}, 32'(o_err_hlen), 0);
    checkOutput({tag, "_errv"}, 32'(o_err_vlen), 0);
  endtask

  // One pixel-clock cycle: drive inputs after the edge, compare at the
  // falling edge, then advance the reference model with this cycle's inputs.
  task automatic applyStimulus(input bit vs, input bit de, input logic [DW-1:0] d);
    bit vsRise, deRise, eHend, eVend, eHlen, nHstr, nVstr, nErrv;
    @(posedge clk);
    #1;
    i_vsync = vs;
    i_de    = de;
    i_data  = d;
    @(negedge clk);
    vsRise = vs && !mPrevVs;
    deRise = de && !mPrevDe;
    eHend  = mActive && (!de || vsRise);
    eVend  = eHend && !vsRise && (mLine == int'(r_vsz) - 1);
    eHlen  = eHend && (mPix + 1 != int'(r_hsz));

    checkOutput("href", 32'(o_href), 32'(eHref));
    checkOutput("data", 32'(o_data), 32'(mData));
    checkOutput("hstr", 32'(o_hstr), 32'(eHstr));
    checkOutput("vstr", 32'(o_vstr), 32'(eVstr));
    checkOutput("hend", 32'(o_hend), 32'(eHend));
    checkOutput("vend", 32'(o_vend), 32'(eVend));
    checkOutput("err_hlen", 32'(o_err_hlen), 32'(eHlen));
    checkOutput("err_vlen", 32'(o_err_vlen), 32'(eErrv));
    if (eHref) begin
      checkOutput("hcnt", 32'(o_hcnt), 32'(mPix));
      checkOutput("vcnt", 32'(o_vcnt), 32'(mLine));
    end

    cntHref  += int'(o_href);
    cntHstr  += int'(o_hstr);
    cntHend  += int'(o_hend);
    cntVstr  += int'(o_vstr);
    cntVend  += int'(o_vend);
    cntErrH  += int'(o_err_hlen);
    cntErrV  += int'(o_err_vlen);
    cntCoinc += int'(o_hstr & o_hend);

    nHstr = 0; nVstr = 0; nErrv = 0;
    if (vsRise) begin
      nErrv   = mOpen;
      mOpen   = 1;
      mLine   = 0;
      mActive = deRise;
      if (deRise) begin
        mPix = 0; nHstr = 1; nVstr = 1;
      end
    end else if (mActive) begin
      if (de) begin
        mPix = (mPix < 4095) ? mPix + 1 : 4095;
      end else begin
        mActive = 0;
        if (mLine == int'(r_vsz) - 1) mOpen = 0;
        else mLine = (mLine < 2047) ? mLine + 1 : 2047;
      end
    end else if (deRise) begin
      if (mOpen) begin
        mActive = 1; mPix = 0; nHstr = 1; nVstr = (mLine == 0);
      end else begin
        nErrv = 1;
      end
    end
    if (de) mData = d;
    eHref   = mActive;
    eHstr   = nHstr;
    eVstr   = nVstr;
    eErrv   = nErrv;
    mPrevVs = vs;
    mPrevDe = de;
  endtask

  task automatic vsPulse();
    applyStimulus(1'b1, 1'b0, 8'($urandom));
    applyStimulus(1'b1, 1'b0, 8'($urandom));
    applyStimulus(1'b0, 1'b0, 8'($urandom));
    applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  // n pixels; vsync rises at pixel vsAt (-1 = never); then gap idle cycles
  task automatic sendLine(input int n, input int vsAt, input int gap);
    bit vs;
    vs = 1'b0;
    for (int p = 0; p < n; p++) begin
      if (p == vsAt) vs = 1'b1;
      applyStimulus(vs, 1'b1, 8'($urandom));
    end
    for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic sendFrame(input int nLines, input int len);
    vsPulse();
    for (int l = 0; l < nLines; l++) sendLine(len, -1, 3);
  endtask

  task automatic checkNominalCounts(input string tag);
    checkOutput({tag, "_href_cnt"}, 32'(cntHref), 32);
    checkOutput({tag, "_hstr_cnt"}, 32'(cntHstr), 4);
    checkOutput({tag, "_hend_cnt"}, 32'(cntHend), 4);
    checkOutput({tag, "_vstr_cnt"}, 32'(cntVstr), 1);
    checkOutput({tag, "_vend_cnt"}, 32'(cntVend), 1);
    checkOutput({tag, "_errh_cnt"}, 32'(cntErrH), 0);
    checkOutput({tag, "_errv_cnt"}, 32'(cntErrV), 0);
  endtask

  initial begin
    int nl;
    int len;
    int vsAt;
    rst = 1'b1; i_vsync = 1'b0; i_de = 1'b0; i_data = '0;
    r_hsz = 12'd8; r_vsz = 11'd4;
    modelReset();
    clearCounts();
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: nominal frame
    $display("[TB] scenario 1: nominal frame");
    clearCounts();
    sendFrame(4, 8);
    checkNominalCounts("s1");

    // 2: short line 2
    $display("[TB] scenario 2: short line");
    clearCounts();
    vsPulse();
    sendLine(8, -1, 3);
    sendLine(8, -1, 3);
    sendLine(6, -1, 3);
    sendLine(8, -1, 3);
    checkOutput("s2_errh_cnt", 32'(cntErrH), 1);
    checkOutput("s2_vend_cnt", 32'(cntVend), 1);

    // 3: vsync mid-line 2 aborts the frame, next frame completes
    $display("[TB] scenario 3: short frame");
    clearCounts();
    vsPulse();
    sendLine(8, -1, 3);
    sendLine(8, -1, 3);
    sendLine(8, 3, 3);
    for (int l = 0; l < 4; l++) sendLine(8, -1, 3);
    checkOutput("s3_errv_cnt", 32'(cntErrV), 1);
    checkOutput("s3_vend_cnt", 32'(cntVend), 1);
    checkOutput("s3_vstr_cnt", 32'(cntVstr), 2);
    checkOutput("s3_hend_cnt", 32'(cntHend), 7);

    // 4: extra line after a complete frame
    $display("[TB] scenario 4: long frame");
    clearCounts();
    sendFrame(4, 8);
    sendLine(8, -1, 3);
    checkOutput("s4_errv_cnt", 32'(cntErrV), 1);
    checkOutput("s4_href_cnt", 32'(cntHref), 32);

    // 5: one-pixel lines
    $display("[TB] scenario 5: one-pixel lines");
    clearCounts();
    r_hsz = 12'd1;
    vsPulse();
    for (int l = 0; l < 4; l++) sendLine(1, -1, $urandom_range(1, 3));
    checkOutput("s5_coinc_cnt", 32'(cntCoinc), 4);
    checkOutput("s5_vend_cnt", 32'(cntVend), 1);
    checkOutput("s5_errh_cnt", 32'(cntErrH), 0);

    // 7: vsync and first pixel in the same cycle
    $display("[TB] scenario 7: vsync with first pixel");
    clearCounts();
    r_hsz = 12'd8;
    sendLine(8, 0, 3);
    for (int l = 0; l < 3; l++) sendLine(8, -1, 3);
    checkNominalCounts("s7");

    // 6: asynchronous reset mid-line, then a nominal frame
    $display("[TB] scenario 6: reset mid-line");
    vsPulse();
    for (int p = 0; p < 4; p++) applyStimulus(1'b0, 1'b1, 8'($urandom));
    @(posedge clk);
    #1;
    i_data = 8'($urandom);
    checkOutput("pre_rst_href", 32'(o_href), 32'(eHref));
    #2 rst = 1'b1;
    #1;
    checkResetOutputs("midline_rst");
    i_de = 1'b0; i_vsync = 1'b0;
    modelReset();
    @(posedge clk);
    #1 rst = 1'b0;
    clearCounts();
    sendFrame(4, 8);
    checkNominalCounts("s6");

    // randomized frames with random sizes, lengths and aborts
    $display("[TB] random frames");
    for (int f = 0; f < 12; f++) begin
      r_hsz = 12'($urandom_range(1, 10));
      r_vsz = 11'($urandom_range(1, 5));
      nl = $urandom_range(1, int'(r_vsz) + 1);
      vsPulse();
      for (int l = 0; l < nl; l++) begin
        len  = $urandom_range(1, 12);
        vsAt = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
        sendLine(len, vsAt, $urandom_range(1, 4));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
